uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart` transmitter among N byte-producing requesters. Each requester presents a byte with a level request. The arbiter latches the winner's byte onto the UART `din`/`send` pair, and holds `send` until the transmitter reports busy. It then acknowledges the requester and waits for the frame to finish before granting again. It sits between application logic (echo path, status reporters, debug taps) and the `uart` instance in a top-level.

## Interface
Parameters:
- `N`, 4, number of requesters; legal 2..8.
- `IdxW`, 2, width of the grant index; must be ≥ clog2(N).
- `TimeoutW`, 8, width of the `send`-without-`txbusy` timeout counter; the timeout is 2**TimeoutW−1 cycles.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester level request; bit i asserts that `data[8*i+7:8*i]` is valid.
- `data`  in  8*N  flattened request bytes; requester i owns slice i.
- `ack`  out  N  one-cycle pulse on bit i when requester i's byte has been accepted by the UART.
- `tx_din`  out  8  byte to the UART `din`.
- `tx_send`  out  1  to the UART `send`.
- `tx_busy`  in  1  from the UART `txbusy`.
- `grant_idx`  out  IdxW  index of the current or last granted requester.
- `active`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse when a send is abandoned.

## Operation
- FSM has three states: IDLE, SEND, WAIT_DONE. Encoding is binary; values come from the shared header.
- Round-robin pointer `ptr` ranges 0..N−1 and resets to 0.
- Winner selection: the winner is the first i with `req[i]` set, scanning `ptr, ptr+1, … N−1, 0, … ptr−1`. Wrap is an explicit compare against N−1, not a power-of-two modulo.

IDLE:
- Grants only when `tx_busy`=0 and `req`≠0.
- On a grant: latch the winner's byte into `tx_din`, set `grant_idx` to the winner, clear the timer, go to SEND.

SEND:
- `tx_send`=1 for every cycle in this state; the timer increments each cycle.
- If `tx_busy`=1: pulse `ack[grant_idx]`, set `ptr` to grant_idx+1 (wrapping), go to WAIT_DONE.
- Else if the timer equals all-ones: pulse `timeout_err`, advance `ptr` the same way, return to IDLE, no `ack`.
- `tx_busy` takes priority over timeout when both hold in the same cycle.

WAIT_DONE:
- Go to IDLE when `tx_busy`=0.

Requester obligations:
- Hold `data` stable from `req` rising until `ack` is seen.
- Deassert `req` on the cycle after `ack`, or the next byte is queued.
- Dropping `req` during SEND does not cancel the send: the byte is already latched, and `ack` still pulses.

## Timing
- All outputs are registered.
- Reset values: `tx_send`=0, `tx_din`=0, `ack`=0, `grant_idx`=0, `active`=0, `timeout_err`=0, `ptr`=0, state IDLE.
- Grant latency: `req` seen at edge k in IDLE → `tx_send`=1 and `tx_din` valid after edge k.
- Ack latency: `tx_busy` first sampled high at edge m → `tx_send`=0 and `ack` high after edge m, for exactly one cycle.
- Minimum gap between frames: `tx_busy` falling sampled at edge p → IDLE after p → next `tx_send` after p+1.
- Simultaneous requests: exactly one grant per arbitration; a requester that just won has the lowest priority next time.
- Asynchronous reset mid-frame:
  - Outputs clear immediately.
  - The UART finishes its frame on its own.
  - After reset, IDLE holds off the next grant until `tx_busy`=0.
  - No `ack` is issued for the interrupted byte; its requester still holds `req` and is re-served.
- `tx_busy` already high on entry to IDLE (for example after reset): no grant, no error.

## Structure
- Shared header `uart_defs.vh` holds:
  - FSM state localparams (ST_IDLE=0, ST_SEND=1, ST_WAIT=2);
  - the byte width constant (8), reused by `uart`.
- One combinational sub-module, `rr_pick`, with parameters N and IdxW:
  - inputs `req`, `ptr`;
  - outputs `any`, `idx`.
- The top FSM, timer and latches live in `uart_tx_arbiter`.
- Target size is about 150–250 lines of RTL including `rr_pick`.

## Test plan
All scenarios use a UART model whose busy rises 2 cycles after `send` and stays high 80 cycles.
- Single request: `req`=0001, `data[7:0]`=0x41 → `tx_din`=0x41, `tx_send` high 3 cycles, `ack`=0001 for one cycle, one frame.
- All four request together with bytes 0x10/0x11/0x12/0x13, each held until its ack → frames sent in order 0x10, 0x11, 0x12, 0x13; `grant_idx` 0,1,2,3; `ptr` wraps to 0.
- Fairness: req0 held continuously (re-raised after each ack), req2 raised once → order 0, 2, 0, …; req2 waits at most one frame.
- Timeout: UART model never raises busy, TimeoutW=4 → `tx_send` high 15 cycles, `timeout_err` pulses once, no `ack`; the next requester is granted.
- Reset: assert `reset_n`=0 during WAIT_DONE with `tx_busy` still high → outputs 0 immediately; after release, no grant until busy falls, then the pending requester is served and acked once.
- Non-power-of-two N=3 with all requesting → grant order 0, 1, 2, 0; `grant_idx` never reaches 3.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Purpose: shared types and constants for the UART transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

    // Byte width on the UART side; the uart transmitter uses the same value.
    localparam int BYTE_W = 8;

    // Arbiter FSM states, binary encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Purpose: round-robin winner pick; first set req bit scanning ptr..N-1 then 0..ptr-1.
// Latency: combinational.
// Backpressure: none; the caller decides when to use the pick.
// Ports: req (request vector), ptr (highest-priority index),
//        any (at least one request), idx (winning index, 0 when any=0).
module rr_pick #(
    parameter int N    = 4,
    parameter int IdxW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic            any,
    output logic [IdxW-1:0] idx
);

    always_comb begin
        logic [IdxW-1:0] cand;
        logic            found;
        cand  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
            // Explicit wrap at N-1 so non-power-of-two N never visits index N.
            cand = (cand == IdxW'(N - 1)) ? '0 : cand + IdxW'(1);
        end
        any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART transmitter among N byte requesters, round-robin.
// Latency: grant 1 cycle after req sampled; ack 1 cycle after tx_busy sampled high.
// Backpressure: holds off grants while tx_busy is high; abandons a send after 2**TimeoutW-1 cycles.
// Ports: clk/reset_n; req/data from requesters, ack pulse back; tx_din/tx_send to the UART,
//        tx_busy from it; grant_idx, active, timeout_err status. All outputs registered.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int IdxW     = 2,
    parameter int TimeoutW = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        req,
    input  logic [BYTE_W*N-1:0] data,
    output logic [N-1:0]        ack,
    output logic [BYTE_W-1:0]   tx_din,
    output logic                tx_send,
    input  logic                tx_busy,
    output logic [IdxW-1:0]     grant_idx,
    output logic                active,
    output logic                timeout_err
);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     gidx_q, gidx_d;
    logic [TimeoutW-1:0] timer_q, timer_d;
    logic [BYTE_W-1:0]   din_q, din_d;
    logic [N-1:0]        ack_q, ack_d;
    logic                send_q, send_d;
    logic                active_q, active_d;
    logic                to_q, to_d;

    logic                pick_any;
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     ptr_next;
    logic [TimeoutW-1:0] timer_inc;

    rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // The requester after the one just served gets top priority next time.
    assign ptr_next  = (gidx_q == IdxW'(N - 1)) ? '0 : gidx_q + IdxW'(1);
    // Timer value including the current SEND cycle, so the abandon happens
    // after exactly 2**TimeoutW-1 cycles of tx_send.
    assign timer_inc = timer_q + TimeoutW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        timer_d = timer_q;
        din_d   = din_q;
        ack_d   = '0;
        to_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // tx_busy may still be high after reset or a timeout; wait it out.
                if (!tx_busy && pick_any) begin
                    for (int i = 0; i < N; i++) begin
                        if (pick_idx == IdxW'(i)) begin
                            din_d = data[BYTE_W*i +: BYTE_W];
                        end
                    end
                    gidx_d  = pick_idx;
                    timer_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                timer_d = timer_inc;
                if (tx_busy) begin
                    for (int i = 0; i < N; i++) begin
                        ack_d[i] = (gidx_q == IdxW'(i));
                    end
                    ptr_d   = ptr_next;
                    state_d = ST_WAIT;
                end else if (timer_inc == '1) begin
                    to_d    = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        send_d   = (state_d == ST_SEND);
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            timer_q  <= '0;
            din_q    <= '0;
            ack_q    <= '0;
            send_q   <= 1'b0;
            active_q <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            timer_q  <= timer_d;
            din_q    <= din_d;
            ack_q    <= ack_d;
            send_q   <= send_d;
            active_q <= active_d;
            to_q     <= to_d;
        end
    end

    assign ack         = ack_q;
    assign tx_din      = din_q;
    assign tx_send     = send_q;
    assign grant_idx   = gidx_q;
    assign active      = active_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: bench for uart_tx_arbiter; one N=4 and one N=3 instance, TimeoutW=4.
// Latency: UART model raises busy 2 cycles after send and holds it 80 cycles.
// Backpressure: model can be told never to raise busy to force the timeout path.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [3:0]  req0;
    logic [31:0] data0;
    logic [3:0]  ack0;
    logic [7:0]  din0;
    logic        send0, busy0, act0, to0;
    logic [1:0]  gidx0;

    logic [2:0]  req1;
    logic [23:0] data1;
    logic [2:0]  ack1;
    logic [7:0]  din1;
    logic        send1, busy1, act1, to1;
    logic [1:0]  gidx1;

    uart_tx_arbiter #(.N(4), .IdxW(2), .TimeoutW(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req(req0), .data(data0), .ack(ack0),
        .tx_din(din0), .tx_send(send0), .tx_busy(busy0), .grant_idx(gidx0),
        .active(act0), .timeout_err(to0)
    );

    uart_tx_arbiter #(.N(3), .IdxW(2), .TimeoutW(4)) dut3 (
        .clk(clk), .reset_n(reset_n), .req(req1), .data(data1), .ack(ack1),
        .tx_din(din1), .tx_send(send1), .tx_busy(busy1), .grant_idx(gidx1),
        .active(act1), .timeout_err(to1)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- UART model (not reset by reset_n) ----------------
    logic [1:0] busy_v  = 2'b00;
    logic [1:0] pend    = 2'b00;
    logic [1:0] no_busy = 2'b00;
    logic [1:0] send_v;
    int         cnt[2];

    assign send_v = {send1, send0};
    assign busy0  = busy_v[0];
    assign busy1  = busy_v[1];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (busy_v[u]) begin
                if (cnt[u] == 1) busy_v[u] <= 1'b0;
                cnt[u] <= cnt[u] - 1;
            end else if (pend[u]) begin
                pend[u]   <= 1'b0;
                busy_v[u] <= 1'b1;
                cnt[u]    <= 80;
            end else if (send_v[u] && !no_busy[u]) begin
                pend[u] <= 1'b1;
            end
        end
    end

    // ---------------- requester driver ----------------
    logic [3:0] sticky0;
    logic [2:0] sticky1;
    logic       rand_en;
    int         raised[4];

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack0[i]) begin
                req0[i] = 1'b0;
            end else if (!req0[i] && (sticky0[i] || (rand_en && $urandom_range(0, 7) == 0))) begin
                data0[8*i +: 8] = sticky0[i] ? (8'hA0 + 8'(i)) : 8'($urandom);
                req0[i] = 1'b1;
                raised[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (ack1[i]) begin
                req1[i] = 1'b0;
            end else if (!req1[i] && sticky1[i]) begin
                data1[8*i +: 8] = 8'h30 + 8'(i);
                req1[i] = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    int         ptr_m[2];
    int         cur_w[2];
    int         slen[2];
    int         ngrant[2];
    int         nto[2];
    int         acked[2][4];
    logic       psend[2];
    logic       pbusy[2];
    logic [3:0] preq[2];
    logic [3:0] pack[2];
    int         iq0[$];
    int         iq1[$];
    int         bq0[$];

    function automatic int pick(input logic [3:0] r, input int p, input int n);
        for (int j = 0; j < n; j++) begin
            if (r[(p + j) % n]) return (p + j) % n;
        end
        return -1;
    endfunction

    task automatic mon(input int u, input int n, input logic send, input logic [7:0] din,
                       input logic [1:0] gidx, input logic act, input logic [3:0] ack,
                       input logic to, input logic [3:0] rq, input logic [31:0] dt,
                       input logic busy);
        int w;
        if (!reset_n) begin
            ptr_m[u] = 0;
            cur_w[u] = 0;
            slen[u]  = 0;
            psend[u] = 1'b0;
            pack[u]  = 4'b0;
        end else begin
            if (send && !psend[u]) begin
                w = pick(preq[u], ptr_m[u], n);
                chk("grant_had_req", 32'(preq[u] != 4'b0), 32'd1);
                if (w < 0) w = 0;
                chk("grant_idx", 32'(gidx), 32'(w));
                chk("tx_din", 32'(din), 32'(dt[8*w +: 8]));
                chk("grant_while_busy", 32'(pbusy[u]), 32'd0);
                cur_w[u] = w;
                slen[u]  = 0;
                ngrant[u]++;
                if (u == 0) begin
                    iq0.push_back(int'(gidx));
                    bq0.push_back(int'(din));
                end else begin
                    iq1.push_back(int'(gidx));
                end
            end
            if (send) begin
                slen[u]++;
                chk("active_in_send", 32'(act), 32'd1);
            end
            if (pack[u] != 4'b0) begin
                chk("ack_one_cycle", 32'(ack), 32'd0);
            end else if (ack != 4'b0) begin
                chk("ack_bit", 32'(ack), 32'd1 << cur_w[u]);
                chk("send_len", 32'(slen[u]), 32'd3);
                chk("send_low_at_ack", 32'(send), 32'd0);
                acked[u][cur_w[u]]++;
                ptr_m[u] = (cur_w[u] + 1) % n;
            end
            if (to) begin
                chk("timeout_len", 32'(slen[u]), 32'd15);
                chk("timeout_no_ack", 32'(ack), 32'd0);
                nto[u]++;
                ptr_m[u] = (cur_w[u] + 1) % n;
            end
            psend[u] = send;
            pack[u]  = ack;
        end
        pbusy[u] = busy;
        preq[u]  = rq;
    endtask

    always @(negedge clk) begin
        mon(0, 4, send0, din0, gidx0, act0, ack0, to0, req0, data0, busy0);
        mon(1, 3, send1, din1, gidx1, act1, {1'b0, ack1}, to1, {1'b0, req1}, {8'h00, data1}, busy1);
    end

    // ---------------- bounded waits ----------------
    function automatic int probe(input int kind, input int u, input int i);
        case (kind)
            0:       return acked[u][i];
            1:       return ngrant[u];
            2:       return nto[u];
            default: return (u == 0) ? int'(req0 == 4'b0 && !act0 && !busy0)
                                     : int'(req1 == 3'b0 && !act1 && !busy1);
        endcase
    endfunction

    task automatic wait_for(input string tag, input int kind, input int u, input int i,
                            input int target, input int budget);
        int c;
        c = 0;
        while (probe(kind, u, i) < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 32'(probe(kind, u, i) >= target), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_send"},   32'(send0), 32'd0);
        chk({pfx, "_din"},    32'(din0),  32'd0);
        chk({pfx, "_ack"},    32'(ack0),  32'd0);
        chk({pfx, "_gidx"},   32'(gidx0), 32'd0);
        chk({pfx, "_active"}, 32'(act0),  32'd0);
        chk({pfx, "_to"},     32'(to0),   32'd0);
    endtask

    // ---------------- scenarios ----------------
    int a1, a3, r_snap[4], a_snap[4];

    initial begin
        req0 = '0; data0 = '0; req1 = '0; data1 = '0;
        sticky0 = '0; sticky1 = '0; rand_en = 1'b0;
        reset_n = 1'b0;
        #12;
        chk_reset_outputs("reset");
        chk("reset_n3_send", 32'(send1), 32'd0);
        chk("reset_n3_active", 32'(act1), 32'd0);
        @(negedge clk); #2 reset_n = 1'b1;

        // N=3, everyone requesting continuously
        @(posedge clk); #2 sticky1 = 3'b111;
        wait_for("n3_grants", 1, 1, 0, 4, 1000);
        sticky1 = '0;
        wait_for("n3_drain", 3, 1, 0, 1, 1000);
        if (iq1.size() >= 4) begin
            chk("n3_order0", 32'(iq1[0]), 32'd0);
            chk("n3_order1", 32'(iq1[1]), 32'd1);
            chk("n3_order2", 32'(iq1[2]), 32'd2);
            chk("n3_order3", 32'(iq1[3]), 32'd0);
        end
        foreach (iq1[k]) chk("n3_idx_range", 32'(iq1[k] < 3), 32'd1);

        // All four at once, in order 0..3
        iq0.delete(); bq0.delete();
        @(posedge clk); #2 data0 = 32'h13121110; req0 = 4'hF;
        wait_for("all4_grants", 1, 0, 0, 4, 1000);
        wait_for("all4_drain", 3, 0, 0, 1, 1000);
        for (int k = 0; k < 4; k++) begin
            if (k < bq0.size()) begin
                chk("all4_byte", 32'(bq0[k]), 32'h10 + 32'(k));
                chk("all4_idx", 32'(iq0[k]), 32'(k));
            end
        end

        // Pointer wrapped to 0: requester 1 beats 3
        iq0.delete();
        @(posedge clk); #2 data0 = 32'h2B002A00; req0 = 4'b1010;
        wait_for("wrap_drain", 3, 0, 0, 1, 1000);
        if (iq0.size() >= 2) begin
            chk("wrap_first", 32'(iq0[0]), 32'd1);
            chk("wrap_second", 32'(iq0[1]), 32'd3);
        end

        // Single request
        iq0.delete(); bq0.delete();
        a1 = acked[0][0];
        @(posedge clk); #2 data0[7:0] = 8'h41; req0 = 4'b0001;
        wait_for("single_drain", 3, 0, 0, 1, 500);
        chk("single_frames", 32'(bq0.size()), 32'd1);
        if (bq0.size() >= 1) chk("single_byte", 32'(bq0[0]), 32'h41);
        chk("single_ack", 32'(acked[0][0] - a1), 32'd1);

        // Fairness: req0 always requesting, req2 once
        iq0.delete();
        @(posedge clk); #2 sticky0 = 4'b0001;
        wait_for("fair_first", 1, 0, 0, ngrant[0] + 1, 300);
        @(posedge clk); #2 data0[23:16] = 8'hC2; req0[2] = 1'b1;
        wait_for("fair_more", 1, 0, 0, ngrant[0] + 2, 500);
        sticky0 = '0;
        wait_for("fair_drain", 3, 0, 0, 1, 1000);
        if (iq0.size() >= 3) begin
            chk("fair_0", 32'(iq0[0]), 32'd0);
            chk("fair_1", 32'(iq0[1]), 32'd2);
            chk("fair_2", 32'(iq0[2]), 32'd0);
        end

        // Timeout: UART never goes busy for the first send
        iq0.delete();
        a1 = acked[0][1]; a3 = acked[0][3];
        no_busy[0] = 1'b1;
        @(posedge clk); #2 data0 = 32'h73007100; req0 = 4'b1010;
        wait_for("to_seen", 2, 0, 0, 1, 100);
        no_busy[0] = 1'b0;
        wait_for("to_drain", 3, 0, 0, 1, 1000);
        chk("to_once", 32'(nto[0]), 32'd1);
        if (iq0.size() >= 3) begin
            chk("to_first", 32'(iq0[0]), 32'd1);
            chk("to_next", 32'(iq0[1]), 32'd3);
            chk("to_retry", 32'(iq0[2]), 32'd1);
        end
        chk("to_ack1", 32'(acked[0][1] - a1), 32'd1);
        chk("to_ack3", 32'(acked[0][3] - a3), 32'd1);

        // Reset during WAIT_DONE with tx_busy high
        a1 = acked[0][1]; a3 = acked[0][3];
        @(posedge clk); #2 data0[15:8] = 8'h51; req0 = 4'b0010;
        wait_for("mid_ack", 0, 0, 1, a1 + 1, 300);
        repeat (5) @(negedge clk);
        @(posedge clk); #2 data0[31:24] = 8'h53; req0[3] = 1'b1;
        @(negedge clk); #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        wait_for("midrst_reserve", 0, 0, 3, a3 + 1, 400);
        wait_for("midrst_drain", 3, 0, 0, 1, 1000);
        chk("midrst_ack_once", 32'(acked[0][3] - a3), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 4; i++) begin
            r_snap[i] = raised[i];
            a_snap[i] = acked[0][i];
        end
        rand_en = 1'b1;
        repeat (3000) @(negedge clk);
        rand_en = 1'b0;
        wait_for("rand_drain", 3, 0, 0, 1, 2000);
        for (int i = 0; i < 4; i++) begin
            chk("rand_scoreboard", 32'(acked[0][i] - a_snap[i]), 32'(raised[i] - r_snap[i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
